// File: rtl/thermostat_pkg.sv
// Shared types and encodings for the thermostat controller slice.
package thermostat_pkg;

  localparam int unsigned CTRL_STATE_W = 2;

  // State encoding as seen on ctrl_state and in the status register
  typedef enum logic [CTRL_STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_HEATING = 2'd1,
    ST_COOLING = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_GT   = 2'd1,
    DIR_EQ   = 2'd2,
    DIR_LT   = 2'd3
  } dir_t;

  // One-hot comparator flags map to a direction; anything else is NONE
  function automatic dir_t classify(input logic gt, input logic eq, input logic lt);
    dir_t d;
    case ({gt, eq, lt})
      3'b100:  d = DIR_GT;
      3'b010:  d = DIR_EQ;
      3'b001:  d = DIR_LT;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/thermostat_ctrl_fsm_sample_confirm.sv
// Classifies comparator samples and confirms a direction after N consecutive matches.
module sample_confirm
  import thermostat_pkg::*;
#(
  parameter int unsigned CONFIRM_COUNT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_valid,
  input  logic temp_greater,
  input  logic temp_equal,
  input  logic temp_lower,
  input  logic clear,
  output dir_t dir_c,
  output logic confirmed_c,
  output logic malformed_c
);

  localparam int unsigned CNT_W = $clog2(CONFIRM_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM_COUNT);

  logic [CNT_W-1:0] cnt_q, cnt_upd, cnt_d;
  dir_t             cand_q, cand_d;

  // Filter update for the current sample, before any external clear
  always_comb begin
    dir_c       = classify(temp_greater, temp_equal, temp_lower);
    malformed_c = sample_valid && (dir_c == DIR_NONE);
    cand_d      = cand_q;
    cnt_upd     = cnt_q;
    if (sample_valid) begin
      if (malformed_c) begin
        cand_d  = DIR_NONE;
        cnt_upd = '0;
      end else if (dir_c == cand_q) begin
        if (cnt_q != CNT_MAX) cnt_upd = cnt_q + CNT_W'(1);
      end else begin
        cand_d  = dir_c;
        cnt_upd = CNT_W'(1);
      end
    end
    confirmed_c = sample_valid && !malformed_c && (cnt_upd == CNT_MAX);
  end

  // A state move or watchdog expiry demands a fresh run of samples
  always_comb begin
    cnt_d = cnt_upd;
    if (clear) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      cand_q <= DIR_NONE;
    end else begin
      cnt_q  <= cnt_d;
      cand_q <= cand_d;
    end
  end

endmodule

// File: rtl/thermostat_ctrl_fsm.sv
// Heater/cooler control FSM with confirmation filter, minimum dwell and sensor watchdog.
module thermostat_ctrl_fsm
  import thermostat_pkg::*;
#(
  parameter int unsigned CONFIRM_COUNT    = 3,
  parameter int unsigned MIN_DWELL_CYCLES = 1000,
  parameter int unsigned TIMEOUT_CYCLES   = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic                    temp_greater,
  input  logic                    temp_equal,
  input  logic                    temp_lower,
  output logic                    heater_on,
  output logic                    cooler_on,
  output logic [CTRL_STATE_W-1:0] ctrl_state,
  output logic                    sensor_timeout,
  output logic                    flag_error
);

  localparam int unsigned DWELL_W = $clog2(MIN_DWELL_CYCLES + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CTRL_STATE_W-1:0] S_IDLE    = CTRL_STATE_W'(ST_IDLE);
  localparam logic [CTRL_STATE_W-1:0] S_HEATING = CTRL_STATE_W'(ST_HEATING);
  localparam logic [CTRL_STATE_W-1:0] S_COOLING = CTRL_STATE_W'(ST_COOLING);

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(MIN_DWELL_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_ARM    = TMO_W'(TIMEOUT_CYCLES - 2);

  logic [CTRL_STATE_W-1:0] state_q, state_d;
  logic [DWELL_W-1:0]      dwell_q, dwell_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    timeout_d;
  logic                    go_c, expire_c, confirm_clr_c;
  dir_t                    dir_c;
  logic                    confirmed_c, malformed_c;

  sample_confirm #(
    .CONFIRM_COUNT(CONFIRM_COUNT)
  ) u_confirm (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .temp_greater(temp_greater),
    .temp_equal  (temp_equal),
    .temp_lower  (temp_lower),
    .clear       (confirm_clr_c),
    .dir_c       (dir_c),
    .confirmed_c (confirmed_c),
    .malformed_c (malformed_c)
  );

  // Next state, dwell, watchdog and confirm-clear decisions
  always_comb begin
    state_d       = state_q;
    dwell_d       = dwell_q;
    tmo_d         = tmo_q;
    timeout_d     = sensor_timeout;
    confirm_clr_c = 1'b0;
    go_c          = confirmed_c && (dwell_q == '0);
    expire_c      = !sample_valid && (tmo_q == TMO_ARM);

    case (state_q)
      S_IDLE: begin
        if (go_c && dir_c == DIR_LT)      state_d = S_HEATING;
        else if (go_c && dir_c == DIR_GT) state_d = S_COOLING;
      end
      S_HEATING: if (go_c && (dir_c == DIR_EQ || dir_c == DIR_GT)) state_d = S_IDLE;
      S_COOLING: if (go_c && (dir_c == DIR_EQ || dir_c == DIR_LT)) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      dwell_d       = DWELL_LOAD;
      confirm_clr_c = 1'b1;
    end else if (dwell_q != '0) begin
      dwell_d = dwell_q - DWELL_W'(1);
    end

    if (sample_valid)          tmo_d = '0;
    else if (tmo_q != TMO_LAST) tmo_d = tmo_q + TMO_W'(1);

    // Expiry only fires without a coincident sample, so it never races a move
    if (expire_c) begin
      state_d       = S_IDLE;
      dwell_d       = '0;
      confirm_clr_c = 1'b1;
      timeout_d     = 1'b1;
    end
    if (sample_valid) timeout_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      dwell_q        <= '0;
      tmo_q          <= '0;
      sensor_timeout <= 1'b0;
      flag_error     <= 1'b0;
      heater_on      <= 1'b0;
      cooler_on      <= 1'b0;
    end else begin
      state_q        <= state_d;
      dwell_q        <= dwell_d;
      tmo_q          <= tmo_d;
      sensor_timeout <= timeout_d;
      flag_error     <= malformed_c;
      heater_on      <= (state_d == S_HEATING);
      cooler_on      <= (state_d == S_COOLING);
    end
  end

  assign ctrl_state = state_q;

endmodule
